if_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
- Holds the PC and drives the instruction-memory request.
- Selects the next PC from sequential, branch, jr and j/jal targets.
- Presents op/rs/rt/rd/func/imm fields to the ID-stage control decoder and consumes that decoder's stall and flush.

---
 rtl/if_stage.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage with the IF/ID pipeline register.
// Define IF_PERF_CNT_EN to add the perf_fetch/perf_bubble counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic [5:0]  id_op,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [5:0]  id_func,
  output logic [15:0] id_imm
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_bubble
`endif
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    WAIT_SQUASH
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc4;
  logic [31:0] tgt;
  logic [31:0] next_pc;
  logic        ld_val;
  logic        ld_bub;

  assign pc4 = pc_q + 32'd4;

  always_comb begin
    tgt = pc4;
    unique case (pcsrc)
      2'b00: tgt = pc4;
      2'b01: tgt = bpc;
      2'b10: tgt = rpc;
      2'b11: tgt = jpc;
      default: tgt = pc4;
    endcase
    next_pc = tgt & 32'hFFFF_FFFC;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    ld_val  = 1'b0;
    ld_bub  = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (stall) begin
          state_d = RUN;
        end else if (flush) begin
          ld_bub = 1'b1;
          pc_d   = next_pc;
          if (!imem_ready) state_d = WAIT_SQUASH;
        end else if (imem_ready) begin
          ld_val = 1'b1;
          pc_d   = next_pc;
        end else begin
          ld_bub = 1'b1;
        end
      end
      WAIT_SQUASH: begin
        if (stall) begin
          state_d = WAIT_SQUASH;
        end else if (flush) begin
          ld_bub = 1'b1;
          pc_d   = next_pc;
        end else begin
          // response for the squashed address is thrown away
          ld_bub = 1'b1;
          if (imem_ready) state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
    if (ld_val) begin
      inst_d  = imem_rdata;
      pc4_d   = pc4;
      valid_d = 1'b1;
    end else if (ld_bub) begin
      inst_d  = NOP_INST;
      pc4_d   = 32'd0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_q, fetch_d;
  logic [31:0] bub_q, bub_d;

  always_comb begin
    fetch_d = fetch_q;
    bub_d   = bub_q;
    if (ld_val && fetch_q != 32'hFFFF_FFFF) fetch_d = fetch_q + 32'd1;
    if (ld_bub && bub_q != 32'hFFFF_FFFF) bub_d = bub_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_q <= 32'd0;
      bub_q   <= 32'd0;
    end else begin
      fetch_q <= fetch_d;
      bub_q   <= bub_d;
    end
  end

  assign perf_fetch  = fetch_q;
  assign perf_bubble = bub_q;
`endif

  assign imem_req  = (state_q != BOOT);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign id_inst   = inst_q;
  assign id_pc4    = pc4_q;
  assign id_valid  = valid_q;
  assign id_op     = inst_q[31:26];
  assign id_rs     = inst_q[25:21];
  assign id_rt     = inst_q[20:16];
  assign id_rd     = inst_q[15:11];
  assign id_func   = inst_q[5:0];
  assign id_imm    = inst_q[15:0];

endmodule
